i2s_unit: RTL

Serial output stage of the audioport, directly downstream of the control unit. Buffers stereo sample frames delivered by the control/DSP path on `tick_in`, requests new frames with `req_out` (the control unit's `req_in`), and shifts them out as a 64-bit-per-frame I2S stream (`sck_out`, `ws_out`, `sdo_out`) while `play_in` is high. Frames already started always complete cleanly on stop.

---
 rtl/i2s_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/i2s_unit.sv
// i2s_unit: stereo frame FIFO feeding a 64-bit-per-frame I2S serialiser.
// FIFO_DEPTH must be a power of two and at least 2; DATA_BITS must be at most 32.
module i2s_unit #(
    parameter int unsigned DATA_BITS  = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 play_in,
    input  logic                 tick_in,
    input  logic [DATA_BITS-1:0] audio0_in,
    input  logic [DATA_BITS-1:0] audio1_in,
    output logic                 req_out,
    output logic                 sck_out,
    output logic                 ws_out,
    output logic                 sdo_out
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PadW = 32 - DATA_BITS;
    localparam int unsigned EntW = 2 * DATA_BITS;

    typedef enum logic [1:0] {StStandby, StPlay, StDrain} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [63:0] frame_q, frame_d;
    logic        req_q, sck_q, ws_q, sdo_q;

    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q;

    logic            boundary, pop, flush;
    logic            fifo_empty, fifo_full, rd_en, wr_en;
    logic [EntW-1:0] rd_data;
    logic [31:0]     slot0, slot1;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign rd_data    = mem_q[rd_ptr_q];
    // Each channel occupies a 32-bit slot, sample left-justified (MSB first, zero tail).
    assign slot0      = 32'(rd_data[DATA_BITS-1:0]) << PadW;
    assign slot1      = 32'(rd_data[EntW-1:DATA_BITS]) << PadW;
    assign rd_en      = pop && !fifo_empty;
    // A full FIFO still accepts a write when the same edge pops an entry.
    assign wr_en      = tick_in && play_in && (!fifo_full || rd_en);

    // Next-state decode: mode transitions, pop/flush strobes, counters and frame load.
    always_comb begin
        boundary = (state_q != StStandby) && (ph_q == 2'd3) && (bitcnt_q == 6'd63);
        state_d  = state_q;
        pop      = 1'b0;
        flush    = 1'b0;
        case (state_q)
            StStandby: begin
                if (play_in) begin
                    state_d = StPlay;
                    pop     = 1'b1;
                end
            end
            StPlay: begin
                if (!play_in) begin
                    // Stopping exactly on a boundary has no frame left to drain.
                    if (boundary) begin
                        state_d = StStandby;
                        flush   = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (boundary) begin
                    pop = 1'b1;
                end
            end
            StDrain: begin
                if (boundary) begin
                    if (play_in) begin
                        state_d = StPlay;
                        pop     = 1'b1;
                    end else begin
                        state_d = StStandby;
                        flush   = 1'b1;
                    end
                end
            end
            default: state_d = StStandby;
        endcase

        if ((state_q == StStandby) || (state_d == StStandby)) begin
            ph_d     = '0;
            bitcnt_d = '0;
        end else begin
            ph_d     = ph_q + 2'd1;
            bitcnt_d = (ph_q == 2'd3) ? bitcnt_q + 6'd1 : bitcnt_q;
        end

        frame_d = frame_q;
        if (flush) begin
            frame_d = '0;
        end else if (pop) begin
            // Underflow plays silence; a same-edge write is stored for the next pop.
            frame_d = fifo_empty ? '0 : {slot0, slot1};
        end
    end

    // Control state, bit counters, frame register and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StStandby;
            ph_q     <= '0;
            bitcnt_q <= '0;
            frame_q  <= '0;
            req_q    <= 1'b0;
            sck_q    <= 1'b0;
            ws_q     <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            bitcnt_q <= bitcnt_d;
            frame_q  <= frame_d;
            req_q    <= pop;
            sck_q    <= ph_d[1];
            ws_q     <= (state_d != StStandby) && (bitcnt_d >= 6'd31) && (bitcnt_d <= 6'd62);
            // Bit b of the frame lives at index 63-b, i.e. ~b for a 6-bit count.
            sdo_q    <= (state_d != StStandby) && frame_d[~bitcnt_d];
        end
    end

    // FIFO pointers and occupancy; flushed when returning to standby.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // FIFO storage; entries are {right, left}.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {audio1_in, audio0_in};
        end
    end

    assign req_out = req_q;
    assign sck_out = sck_q;
    assign ws_out  = ws_q;
    assign sdo_out = sdo_q;

endmodule
